instr_line_fill: RTL
====================

Name: instr_line_fill

Overview:
- Memory-side fill engine directly downstream of the L1 instruction cache.
- Accepts the cache's line request (mem_req / mem_address) and fetches 8 consecutive 32-bit words from a word-wide backing memory.
- Assembles the 8 words into a 256-bit line and returns it with a one-cycle mem_valid pulse.
- Word packing matches the cache's word-select convention: word at byte offset 0 lands in bits [255:224].

Parameters:
- LINE_WORDS, 8: words per line. Only 8 is supported; the mem_data width is 32*LINE_WORDS.
- ACK_TIMEOUT, 1023: max consecutive FETCH cycles with word_req high and no word_ack before the fill aborts. 0 disables the timeout.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- mem_req  input  1  line request from L1 icache
- mem_address  input  32  line address from L1; bits [4:0] ignored
- line_inval  input  1  invalidate line buffer; used only with LINE_BUF_EN
- mem_data  output  256  assembled line; word k at bits [255-32k : 224-32k]
- mem_valid  output  1  one-cycle pulse, mem_data valid
- busy  output  1  high in any state other than IDLE
- fill_err  output  1  one-cycle pulse on timeout abort
- word_req  output  1  backing-memory read request
- word_addr  output  32  byte address of the current word, always 4-aligned
- word_rdata  input  32  read data, valid when word_ack=1
- word_ack  input  1  word accepted/returned; sampled only while word_req=1

Behaviour:
- Reset values: state IDLE; mem_data=0, mem_valid=0, busy=0, fill_err=0, word_req=0, word_addr=0; word index=0; wait counter=0; line buffer invalid. Reset mid-fill aborts immediately: no mem_valid, no fill_err.
- States: IDLE, FETCH, RESP, COOL.
- IDLE:
  - mem_req=1 at an edge: latch base={mem_address[31:5],5'b0}, set word_addr=base, word_req=1, index=0, go to FETCH.
  - mem_req=0: remain in IDLE.
- FETCH:
  - word_req held high.
  - On an edge with word_ack=1: write word_rdata into slot index, index+1, word_addr+4, wait counter cleared.
  - After the 8th ack: word_req=0, go to RESP.
  - Memory may ack in the first FETCH cycle, so zero-wait memory gives mem_valid 9 cycles after request capture.
  - mem_req deasserting during FETCH is ignored; the fill completes.
  - word_addr never crosses the 32-byte line: last word is base+28, no wrap into the next line.
- RESP: mem_valid=1 for exactly one cycle, then go to COOL.
- COOL: one cycle with mem_req ignored. This absorbs the cache still holding mem_req on the cycle it samples mem_valid. Then go to IDLE.
- mem_data holds the last completed line until the next fill overwrites it. Slots are written in place during a fill, so partially updated contents during FETCH are don't-care.
- Timeout (ACK_TIMEOUT>0):
  - Wait counter increments each FETCH cycle without an ack.
  - When it reaches ACK_TIMEOUT: word_req=0, fill_err pulses one cycle, go to COOL. No mem_valid is generated.
  - The line buffer is invalidated.
- word_ack while word_req=0 is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: INSTR_LINE_FILL_LINE_BUF_EN.
- With the macro:
  - A single-entry buffer keeps the tag (base[31:5]) of the last successfully delivered line.
  - In IDLE, if mem_req=1, the buffer is valid, the tag matches and line_inval=0: go directly to RESP with mem_data unchanged. word_req stays 0, and mem_valid fires 1 cycle after capture.
  - line_inval=1 at any edge clears the valid bit. If it coincides with a matching request, the request is treated as a miss.
  - A completed fill sets the tag and valid bit.
- Without the macro: every request performs a full 8-word fetch; line_inval is ignored; no tag storage is built.

Test Plan:
- Zero-wait fill: mem_req with mem_address=0x0000_1234; memory acks every cycle with rdata = addr ^ 0xA5A5_0000.
  - word_addr must run 0x1220 through 0x123C.
  - mem_valid must pulse at cycle 9, with mem_data[255:224]=0xA5A5_1220 and mem_data[31:0]=0xA5A5_123C.
- Wait states: same request with a 3-cycle gap before each ack. mem_valid must pulse exactly once, at cycle 33, with identical data.
- mem_req held high through RESP into COOL: exactly one fill occurs; a second fill starts only if mem_req is still 1 in IDLE.
- Timeout with ACK_TIMEOUT=4: acks stop after word 2.
  - fill_err must pulse 4 cycles after the last ack.
  - mem_valid must never assert; busy must return to 0 after COOL.
- Reset mid-fill: RESET=1 asynchronously during word 5. All outputs must be at reset values before the next edge; a new request afterwards fetches from word 0.
- LINE_BUF_EN: a repeat request to 0x1220 gives mem_valid 1 cycle after capture with no word_req. After a line_inval pulse, the same request performs a full 8-word fetch.

Source files
------------

// File: rtl/instr_line_fill.sv
// instr_line_fill: memory-side fill engine for the L1 instruction cache.
// Fetches LINE_WORDS consecutive 32-bit words from a word-wide memory and
// returns them as one line (word 0 in the top bits) with a one-cycle mem_valid.
// An ack that never arrives aborts the fill after ACK_TIMEOUT cycles (0 = never).
// Optional single-entry line buffer: define INSTR_LINE_FILL_LINE_BUF_EN.
module instr_line_fill #(
    parameter int LINE_WORDS  = 8,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     mem_req,
    input  logic [31:0]              mem_address,
    input  logic                     line_inval,
    output logic [32*LINE_WORDS-1:0] mem_data,
    output logic                     mem_valid,
    output logic                     busy,
    output logic                     fill_err,
    output logic                     word_req,
    output logic [31:0]              word_addr,
    input  logic [31:0]              word_rdata,
    input  logic                     word_ack
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, RESP, COOL} state_e;

    state_e                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [31:0]              addr_q, addr_d;
    logic [TW-1:0]            wait_q, wait_d;
    logic                     err_q, err_d;
    logic [32*LINE_WORDS-1:0] data_q;
    logic                     ack_fetch, fill_done, abort, hit;

    // word_ack only counts while a word is actually being requested
    assign ack_fetch = (state_q == FETCH) && word_ack;
    assign fill_done = ack_fetch && (idx_q == IDX_LAST);
    // abort on the edge where the no-ack run would reach ACK_TIMEOUT
    assign abort     = (ACK_TIMEOUT > 0) && (state_q == FETCH) && !word_ack
                       && (wait_q == TO_LAST);

`ifdef INSTR_LINE_FILL_LINE_BUF_EN
    logic [26:0] tag_q;
    logic        tag_vld_q;
    logic        unused_lo;

    assign unused_lo = ^mem_address[4:0];
    // an invalidate on the capture edge forces a miss
    assign hit = tag_vld_q && !line_inval && (tag_q == mem_address[31:5]);

    // Tag of the last delivered line; invalidate or aborted fill drops it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else if (line_inval || abort) begin
            tag_vld_q <= 1'b0;
        end else if (fill_done) begin
            tag_q     <= addr_q[31:5];
            tag_vld_q <= 1'b1;
        end
    end
`else
    logic unused_in;

    assign unused_in = ^{mem_address[4:0], line_inval};
    assign hit       = 1'b0;
`endif

    // Next-state logic: capture, word walk, one-cycle response, cool-down
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    if (hit) begin
                        state_d = RESP;
                    end else begin
                        addr_d  = {mem_address[31:5], 5'b0};
                        idx_d   = '0;
                        wait_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (word_ack) begin
                    wait_d = '0;
                    idx_d  = idx_q + 1'b1;
                    // the last word stays at base+28; never step into the next line
                    if (idx_q == IDX_LAST) state_d = RESP;
                    else                   addr_d  = addr_q + 32'd4;
                end else if (abort) begin
                    err_d   = 1'b1;
                    state_d = COOL;
                end else if (ACK_TIMEOUT > 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP:    state_d = COOL;
            // the cache may still hold mem_req while it samples mem_valid
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and fetch bookkeeping registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Drop each returned word into its slot; word 0 occupies the top bits
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)          data_q <= '0;
        else if (ack_fetch) data_q[32*(LINE_WORDS-1-int'(idx_q)) +: 32] <= word_rdata;
    end

    assign mem_data  = data_q;
    assign mem_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign fill_err  = err_q;
    assign word_req  = (state_q == FETCH);
    assign word_addr = addr_q;

endmodule
